// File: rtl/if_stage0_fq.sv
`default_nettype none
// ============================================================================
// Module   : if_stage0_fq
// Brief    : Fetch-address stage. Owns the fetch PC, issues aligned
//            fetch-group requests to the I-cache, follows the BPU next-PC
//            prediction and records each accepted group in a small fetch
//            queue that IF1 drains with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage0_fq #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          FETCH_WIDTH = 4,
  parameter int          DEPTH       = 4,
  parameter logic [2:0]  UC_SEG      = 3'b101
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_IF,
  input  logic [31:0]                jump_pc,
  output logic                       valid,
  output logic [31:0]                iaddr,
  output logic                       uncached,
  input  logic                       addr_ok,
  output logic [31:0]                pc_to_BPU,
  input  logic [FETCH_WIDTH-1:0]     pc_is_jump,
  input  logic [FETCH_WIDTH-1:0]     pc_valid,
  input  logic [31:0]                pre_nextpc,
  output logic                       if1_valid,
  output logic [31:0]                if1_pc,
  output logic [FETCH_WIDTH-1:0]     if1_mask,
  output logic [FETCH_WIDTH-1:0]     if1_taken,
  input  logic                       IF1_ready,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int              c_W     = $clog2(FETCH_WIDTH);
  localparam int              c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_DEPTH = (c_AW+1)'(DEPTH);

  logic [31:0]            r_pc;
  logic [c_AW-1:0]        r_head;
  logic [c_AW-1:0]        r_tail;
  logic [c_AW:0]          r_count;

  // Queue storage; deliberately not reset, stale data is gated at the output
  logic [31:0]            r_q_pc    [DEPTH];
  logic [FETCH_WIDTH-1:0] r_q_mask  [DEPTH];
  logic [FETCH_WIDTH-1:0] r_q_taken [DEPTH];

  logic [3:0]             w_off;
  logic [FETCH_WIDTH-1:0] w_base;
  logic [FETCH_WIDTH-1:0] w_mask;
  logic [FETCH_WIDTH-1:0] w_taken;
  logic                   w_full;
  logic                   w_acc;
  logic                   w_deq;
  logic                   w_unused_lsb;

  // Slot offset of the PC inside its fetch group; a 1-wide group has none
  generate
    if (c_W > 0) begin : g_off
      assign w_off = 4'(r_pc[c_W+1:2]);
    end else begin : g_off_zero
      assign w_off = 4'd0;
    end
  endgenerate

  // Slot mask: valid slots at/after the PC offset, truncated after the first taken slot
  always_comb begin
    logic cut;
    cut    = 1'b0;
    w_base = '0;
    w_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_base[i] = (4'(i) >= w_off) && pc_valid[i];
      w_mask[i] = w_base[i] && !cut;
      if (w_base[i] && pc_is_jump[i]) begin
        cut = 1'b1;
      end
    end
  end

  assign w_taken = pc_is_jump & w_mask;

  // Request side: a same-cycle dequeue never frees a slot for a same-cycle enqueue
  assign w_full    = (r_count == c_DEPTH);
  assign valid     = !rst && !flush_IF && !w_full;
  assign w_acc     = valid && addr_ok;
  assign iaddr     = r_pc;
  assign pc_to_BPU = r_pc;
  assign uncached  = (r_pc[31:29] == UC_SEG);

  // Predicted targets are word-aligned on entry, so the low bits are dropped
  assign w_unused_lsb = ^pre_nextpc[1:0];

  // Head side: zero-latency view of the head entry, zeroed when empty
  assign if1_valid = (r_count != '0);
  assign w_deq     = if1_valid && IF1_ready;
  assign if1_pc    = if1_valid ? r_q_pc[r_head]    : '0;
  assign if1_mask  = if1_valid ? r_q_mask[r_head]  : '0;
  assign if1_taken = if1_valid ? r_q_taken[r_head] : '0;
  assign q_count   = r_count;

  // PC, pointers and occupancy; reset beats flush, flush beats accept/dequeue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_IF) begin
      r_pc    <= jump_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) begin
        r_pc   <= {pre_nextpc[31:2], 2'b00};
        r_tail <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_acc, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record the accepted fetch group at the tail
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_q_pc[r_tail]    <= r_pc;
      r_q_mask[r_tail]  <= w_mask;
      r_q_taken[r_tail] <= w_taken;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage0_fq.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage0_fq
// Brief    : Directed self-checking bench for if_stage0_fq (FW=4, DEPTH=4).
//            A small PC/queue model tracks expected iaddr and head PCs;
//            slot masks are checked against hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage0_fq;

  localparam logic [31:0] c_RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_IF;
  logic [31:0] jump_pc;
  logic        valid;
  logic [31:0] iaddr;
  logic        uncached;
  logic        addr_ok;
  logic [31:0] pc_to_BPU;
  logic [3:0]  pc_is_jump;
  logic [3:0]  pc_valid;
  logic [31:0] pre_nextpc;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic [3:0]  if1_mask;
  logic [3:0]  if1_taken;
  logic        IF1_ready;
  logic [2:0]  q_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  if_stage0_fq #(
    .RESET_PC    (c_RESET_PC),
    .FETCH_WIDTH (4),
    .DEPTH       (4),
    .UC_SEG      (3'b101)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .flush_IF   (flush_IF),
    .jump_pc    (jump_pc),
    .valid      (valid),
    .iaddr      (iaddr),
    .uncached   (uncached),
    .addr_ok    (addr_ok),
    .pc_to_BPU  (pc_to_BPU),
    .pc_is_jump (pc_is_jump),
    .pc_valid   (pc_valid),
    .pre_nextpc (pre_nextpc),
    .if1_valid  (if1_valid),
    .if1_pc     (if1_pc),
    .if1_mask   (if1_mask),
    .if1_taken  (if1_taken),
    .IF1_ready  (IF1_ready),
    .q_count    (q_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock, updating the reference model from the inputs seen at the edge
  task automatic tick();
    int          sz;
    bit          enq;
    bit          deq;
    logic [31:0] npc;
    sz  = m_q.size();
    enq = !rst && !flush_IF && (sz < 4) && addr_ok;
    deq = (sz != 0) && IF1_ready;
    npc = {pre_nextpc[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = c_RESET_PC;
      m_q.delete();
    end else if (flush_IF) begin
      m_pc = jump_pc;
      m_q.delete();
    end else begin
      if (deq) void'(m_q.pop_front());
      if (enq) begin
        m_q.push_back(m_pc);
        m_pc = npc;
      end
    end
  endtask

  // Compare request side and head against the model
  task automatic chk_state(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ".valid"},     32'(valid),     32'(!rst && !flush_IF && (sz < 4)));
    check({tag, ".iaddr"},     iaddr,          m_pc);
    check({tag, ".q_count"},   32'(q_count),   32'(sz));
    check({tag, ".if1_valid"}, 32'(if1_valid), 32'(sz != 0));
    check({tag, ".if1_pc"},    if1_pc,         (sz != 0) ? m_q[0] : 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush_IF = 1'b0; jump_pc = '0; addr_ok = 1'b0;
    pc_is_jump = '0; pc_valid = '0; pre_nextpc = '0; IF1_ready = 1'b0;
    m_pc = c_RESET_PC;
    tick();
    addr_ok = 1'b1; IF1_ready = 1'b1;
    tick();
    #1;
    check("rst.valid",     32'(valid),     32'h0);
    check("rst.if1_valid", 32'(if1_valid), 32'h0);
    check("rst.q_count",   32'(q_count),   32'h0);
    check("rst.if1_pc",    if1_pc,         32'h0);
    check("rst.if1_mask",  32'(if1_mask),  32'h0);
    check("rst.if1_taken", 32'(if1_taken), 32'h0);

    // Reset and stream
    rst = 1'b0; addr_ok = 1'b1; IF1_ready = 1'b1; pc_valid = 4'hf;
    pre_nextpc = m_pc + 32'd16; #1;
    check("s0.valid",     32'(valid),     32'h1);
    check("s0.iaddr",     iaddr,          32'h1c000000);
    check("s0.pc_to_BPU", pc_to_BPU,      32'h1c000000);
    check("s0.uncached",  32'(uncached),  32'h0);
    check("s0.if1_valid", 32'(if1_valid), 32'h0);
    tick(); pre_nextpc = m_pc + 32'd16; #1;
    check("s1.iaddr",    iaddr,         32'h1c000010);
    check("s1.if1_pc",   if1_pc,        32'h1c000000);
    check("s1.if1_mask", 32'(if1_mask), 32'hf);
    check("s1.if1_tkn",  32'(if1_taken), 32'h0);
    check("s1.q_count",  32'(q_count),  32'h1);
    tick(); pre_nextpc = m_pc + 32'd16; #1;
    check("s2.iaddr",  iaddr,  32'h1c000020);
    check("s2.if1_pc", if1_pc, 32'h1c000010);
    chk_state("s2");

    // Unaligned entry plus taken slot
    flush_IF = 1'b1; jump_pc = 32'h1c000008; #1;
    check("fl.valid", 32'(valid), 32'h0);
    tick();
    flush_IF = 1'b0; IF1_ready = 1'b0; pc_is_jump = 4'b0100; pre_nextpc = 32'h1c000010; #1;
    check("ua.iaddr",     iaddr,          32'h1c000008);
    check("ua.q_count",   32'(q_count),   32'h0);
    check("ua.if1_valid", 32'(if1_valid), 32'h0);
    tick();
    pc_is_jump = 4'b0010; pre_nextpc = 32'h1c000020; IF1_ready = 1'b1; #1;
    check("ua.if1_pc",    if1_pc,          32'h1c000008);
    check("ua.if1_mask",  32'(if1_mask),   32'h4);
    check("ua.if1_taken", 32'(if1_taken),  32'h4);
    check("ua.iaddr2",    iaddr,           32'h1c000010);

    // Taken cut-off on an aligned PC
    tick();
    addr_ok = 1'b0; IF1_ready = 1'b0; pc_is_jump = 4'b0000; #1;
    check("cut.if1_pc",    if1_pc,         32'h1c000010);
    check("cut.if1_mask",  32'(if1_mask),  32'h3);
    check("cut.if1_taken", 32'(if1_taken), 32'h2);
    check("cut.q_count",   32'(q_count),   32'h1);

    // Back-pressure until full
    flush_IF = 1'b1; jump_pc = 32'h1c000100;
    tick();
    flush_IF = 1'b0; addr_ok = 1'b1; IF1_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pre_nextpc = m_pc + 32'd16; #1;
      chk_state("bp");
      tick();
    end
    pre_nextpc = m_pc + 32'd16; #1;
    check("full.q_count", 32'(q_count), 32'h4);
    check("full.valid",   32'(valid),   32'h0);
    check("full.iaddr",   iaddr,        32'h1c000140);
    check("full.if1_pc",  if1_pc,       32'h1c000100);
    IF1_ready = 1'b1; #1;
    check("full.deq_valid", 32'(valid), 32'h0);
    tick();
    IF1_ready = 1'b0; #1;
    check("pop.q_count", 32'(q_count), 32'h3);
    check("pop.valid",   32'(valid),   32'h1);
    check("pop.if1_pc",  if1_pc,       32'h1c000110);

    // Simultaneous enqueue/dequeue at count 2, wrapping both pointers
    addr_ok = 1'b0; IF1_ready = 1'b1;
    tick();
    addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pre_nextpc = m_pc + 32'd16; #1;
      check("sim.q_count", 32'(q_count), 32'h2);
      chk_state("sim");
      tick();
    end
    #1;
    check("sim.end_pc", if1_pc, 32'h1c0001a0);
    chk_state("sim_end");

    // Flush while full
    IF1_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pre_nextpc = m_pc + 32'd16;
      tick();
    end
    #1;
    check("ff.q_count", 32'(q_count), 32'h4);
    flush_IF = 1'b1; jump_pc = 32'h1c001000; #1;
    check("ff.valid", 32'(valid), 32'h0);
    tick();
    flush_IF = 1'b0; addr_ok = 1'b0; #1;
    check("ff.q_count",   32'(q_count),   32'h0);
    check("ff.if1_valid", 32'(if1_valid), 32'h0);
    check("ff.iaddr",     iaddr,          32'h1c001000);
    check("ff.if1_pc",    if1_pc,         32'h0);
    check("ff.valid2",    32'(valid),     32'h1);

    // Uncached segment
    flush_IF = 1'b1; jump_pc = 32'ha0000040;
    tick();
    flush_IF = 1'b0; #1;
    check("uc.iaddr",    iaddr,         32'ha0000040);
    check("uc.uncached", 32'(uncached), 32'h1);

    // Reset during a stall
    addr_ok = 1'b1; pre_nextpc = 32'ha0000050;
    tick();
    pre_nextpc = 32'ha0000060;
    tick();
    addr_ok = 1'b0; #1;
    check("rs.q_count", 32'(q_count), 32'h2);
    rst = 1'b1; #1;
    check("rs.valid", 32'(valid), 32'h0);
    tick();
    rst = 1'b0; #1;
    check("rs.iaddr",     iaddr,          c_RESET_PC);
    check("rs.q_count",   32'(q_count),   32'h0);
    check("rs.if1_valid", 32'(if1_valid), 32'h0);
    check("rs.if1_pc",    if1_pc,         32'h0);
    check("rs.valid2",    32'(valid),     32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage0_fq.md
Name: if_stage0_fq

Overview:
- Next-generation fetch-address stage. Owns the fetch PC, issues aligned fetch-group requests to the I-cache, and steers the next PC from the BPU.
- Each accepted request is recorded in a parametrised fetch queue (PC plus per-slot valid and taken masks). IF1 pops the queue with a valid/ready handshake.
- Redirects (`flush_IF` with `jump_pc`) override everything.

Parameters:
- RESET_PC, 32'h1c000000, first PC requested after reset.
- FETCH_WIDTH, 4, instructions per fetch group; power of 2, range 1..8.
- DEPTH, 4, fetch-queue entries; power of 2, range 2..16.
- UC_SEG, 3'b101, value of iaddr[31:29] marking an uncached segment.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_IF  in  1  redirect: discard queue and in-flight state.
- jump_pc  in  32  redirect target; sampled when flush_IF=1.
- valid  out  1  I-cache request valid.
- iaddr  out  32  request address; equals current PC.
- uncached  out  1  iaddr[31:29]==UC_SEG.
- addr_ok  in  1  I-cache accepts the request this cycle.
- pc_to_BPU  out  32  current PC.
- pc_is_jump  in  FETCH_WIDTH  BPU taken prediction per slot.
- pc_valid  in  FETCH_WIDTH  BPU slot valid.
- pre_nextpc  in  32  BPU predicted next fetch PC.
- if1_valid  out  1  queue head valid.
- if1_pc  out  32  head PC.
- if1_mask  out  FETCH_WIDTH  head final slot-valid mask.
- if1_taken  out  FETCH_WIDTH  head taken mask.
- IF1_ready  in  1  IF1 consumes the head this cycle.
- q_count  out  log2(DEPTH)+1  occupancy, for debug and perf counting.

Behaviour:
- Let W = log2(FETCH_WIDTH) and off = pc_r[W+1:2].
- **Request:** valid = !rst && !flush_IF && (q_count < DEPTH). Request acceptance is `acc = valid && addr_ok`.
- **Slot mask (combinational, from the current PC):**
  - base[i] = (i >= off) && pc_valid[i].
  - A slot is cut off if any earlier slot j < i, with j >= off, has pc_is_jump[j]=1 and base[j]=1.
  - mask = base with the cut-off slots cleared. The first taken slot itself is kept.
  - taken = pc_is_jump & mask.
- **Accept:** on `acc`, enqueue {pc_r, mask, taken} at the tail and set pc_r <= pre_nextpc. A pre_nextpc that is not word-aligned is forced to have bits [1:0]=0.
- **Stall:** without `acc`, pc_r holds and nothing is enqueued.
- **Dequeue:** deq = if1_valid && IF1_ready. The head advances.
  - if1_valid = (q_count != 0).
  - The head fields are driven combinationally from the head entry, zero latency.
- **Simultaneous enqueue/dequeue:** count is unchanged and both pointers advance.
  - When full, valid=0. A same-cycle deq does not enable a same-cycle enq.
  - An enqueue into an empty queue is visible on if1_* the next cycle. There is no bypass.
- **Pointers:** head and tail are log2(DEPTH) bits and wrap modulo DEPTH. q_count ranges 0..DEPTH.
- **Flush** has priority over acc and deq:
  - pc_r <= jump_pc; head, tail and count go to 0.
  - Any addr_ok seen in the flush cycle is ignored, because valid=0.
  - Next cycle: valid=1 with iaddr=jump_pc.
- **Reset** has priority over flush. State after reset:
  - pc_r=RESET_PC, count=0, head=tail=0.
  - Outputs: valid=0, if1_valid=0, if1_pc/if1_mask/if1_taken=0.
  - The first cycle after reset deasserts shows valid=1 with iaddr=RESET_PC.
  - Reset mid-stall discards all queue contents.
- **Queue storage:** entries need no reset. Outputs must not expose stale data, so the if1_* data fields are gated to 0 when if1_valid=0.

Test Plan:
- **Reset and stream** (FW=4, D=4): release rst, addr_ok=1, pre_nextpc=pc+16, IF1_ready=1, pc_valid=4'hf, no taken.
  - iaddr sequence 1c000000, 1c000010, 1c000020.
  - if1_pc follows one cycle behind each accept; if1_mask=4'hf.
- **Unaligned entry plus taken slot:** flush_IF with jump_pc=1c000008, then pc_is_jump=4'b0100.
  - Head after accept: if1_pc=1c000008, if1_mask=4'b0100, if1_taken=4'b0100.
- **Taken cut-off:** aligned PC, pc_is_jump=4'b0010.
  - if1_mask=4'b0011, if1_taken=4'b0010.
- **Back-pressure and full:** IF1_ready=0, addr_ok=1, 6 cycles.
  - Exactly 4 enqueues, q_count=4, valid=0, iaddr frozen at the 5th PC.
  - Raise IF1_ready for one cycle: count goes to 3, and valid=1 again the next cycle.
- **Simultaneous enq/deq at count=2:** count stays 2, and pointers wrap correctly after 8 cycles, with FIFO order preserved.
- **Flush while full, plus reset mid-operation:**
  - flush_IF with jump_pc=1c001000: next cycle q_count=0, if1_valid=0, iaddr=1c001000.
  - Assert rst during a stall: iaddr=RESET_PC and q_count=0 the cycle after rst deasserts.
